// File: rtl/mul_div_if.sv
// Request/result bundle between execute-stage control and the iterative multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide: one shift-add or restoring shift-subtract step per clock,
// working on operand magnitudes with a single sign-correction cycle at the end.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               done_r, dbz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r, ma, mb;
  logic               sa, sb;
  logic [2*WIDTH-1:0] acc, acc_step;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    sa_in, sb_in;
  logic [WIDTH-1:0]        ma_in, mb_in;

  logic [WIDTH:0]     mul_sum, rem_ext, div_trial;
  logic               div_ge, div_zero;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  function automatic logic [2*WIDTH-1:0] neg_dbl(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Operand capture: signs and magnitudes for the signed ops (op[0]=0)
  assign a_s   = bus.operand_a;
  assign b_s   = bus.operand_b;
  assign sa_in = ~bus.op[0] & a_s[WIDTH-1];
  assign sb_in = ~bus.op[0] & b_s[WIDTH-1];
  assign ma_in = sa_in ? $unsigned(-a_s) : bus.operand_a;
  assign mb_in = sb_in ? $unsigned(-b_s) : bus.operand_b;

  // Iteration step: acc = {partial/remainder, multiplier/quotient bits}
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
    rem_ext   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (rem_ext >= {1'b0, mb});
    div_trial = rem_ext - {1'b0, mb};
    if (op_r[1]) begin
      if (div_ge) acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    div_zero = op_r[1] && (mb == '0);
    prod_fix = neg_dbl(acc, sa ^ sb);
    quo_fix  = neg_w(acc[WIDTH-1:0], sa ^ sb);
    rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], sa);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state  <= state_nx;
      done_r <= (state == FIX);
      case (state)
        IDLE: if (bus.start) begin
          cnt   <= CW'(WIDTH - 1);
          dbz_r <= 1'b0;
        end
        RUN:  if (cnt != '0) cnt <= cnt - CW'(1);
        FIX: begin
          dbz_r <= div_zero;
          if (div_zero) begin
            hi_r <= a_r;
            lo_r <= '1;
          end else if (op_r[1]) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      op_r <= bus.op;
      a_r  <= bus.operand_a;
      sa   <= sa_in;
      sb   <= sb_in;
      ma   <= ma_in;
      mb   <= mb_in;
      acc  <= bus.op[1] ? {{WIDTH{1'b0}}, ma_in} : {{WIDTH{1'b0}}, mb_in};
    end else if (state == RUN) begin
      acc  <= acc_step;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a cycle-level arithmetic model checked every cycle,
// plus literal expected results for each directed operation.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int bcnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference using native 64-bit / signed integer operators
  function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l, output logic d);
    longint sp;
    logic [63:0] up;
    int q, r;
    d = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        up = sp;
        h = up[63:32]; l = up[31:0];
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        h = up[63:32]; l = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          h = x; l = 32'hFFFF_FFFF; d = 1'b1;
        end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          h = 32'd0; l = 32'h8000_0000;
        end else if (o == 2'd2) begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          h = r; l = q;
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  logic        m_busy = 0, m_done = 0, m_dbz = 0, p_dbz = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_hi = 0; m_lo = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
        end
      end else if (bus.start) begin
        m_busy = 1;
        m_left = W + 1;
        m_dbz  = 0;
        model_op(bus.op, bus.operand_a, bus.operand_b, p_hi, p_lo, p_dbz);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cyc_done", {31'd0, bus.done}, {31'd0, m_done});
      cmp("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
      cmp("cyc_hi", bus.hi, m_hi);
      cmp("cyc_lo", bus.lo, m_lo);
      cmp("cyc_dbz", {31'd0, bus.div_by_zero}, {31'd0, m_dbz});
    end
  end

  // Call at a negedge; start is sampled at the following posedge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1; bus.op = o; bus.operand_a = x; bus.operand_b = y;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bcnt = bus.busy ? 1 : 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - e0;
        break;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int lat;
    issue(o, x, y);
    wait_done(lat);
    cmp({name, "_lat"}, lat, 32'd33);
    cmp({name, "_hi"}, bus.hi, eh);
    cmp({name, "_lo"}, bus.lo, el);
    cmp({name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ed});
  endtask

  initial begin
    int lat, nd;
    bus.start = 1'b0; bus.op = 2'd0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(negedge clk);
    cmp("rst_busy", {31'd0, bus.busy}, 32'd0);
    cmp("rst_done", {31'd0, bus.done}, 32'd0);
    cmp("rst_hi", bus.hi, 32'd0);
    cmp("rst_lo", bus.lo, 32'd0);
    cmp("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // MULTU max*max, with busy-length check
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    cmp("multu_max_lat", lat, 32'd33);
    cmp("multu_max_busy", bcnt, 32'd33);
    cmp("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    cmp("multu_max_lo", bus.lo, 32'h0000_0001);
    @(negedge clk);

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min2", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_negb", 2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("divu_zero", 2'd3, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    repeat (4) @(negedge clk);
    cmp("dbz_held", {31'd0, bus.div_by_zero}, 32'd1);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);

    // Restart ignored while busy, then back-to-back issue in the done cycle
    issue(2'd1, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd2; bus.operand_b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    cmp("ignore_lat", lat, 32'd33);
    cmp("ignore_lo", bus.lo, 32'd42);
    cmp("ignore_hi", bus.hi, 32'd0);
    issue(2'd1, 32'd3, 32'd3);
    wait_done(lat);
    cmp("b2b_lat", lat, 32'd33);
    cmp("b2b_lo", bus.lo, 32'd9);
    @(negedge clk);

    // Asynchronous reset during RUN
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    cmp("arst_busy", {31'd0, bus.busy}, 32'd0);
    cmp("arst_hi", bus.hi, 32'd0);
    cmp("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    cmp("arst_no_done", nd, 32'd0);
    run_op("after_rst", 2'd3, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
